uut_perf_recorder: RTL

//  Sits directly downstream of the autotest UUT control outputs (uut_start, uut_finish, UUT parameter buses).

---
 rtl/uut_perf_recorder_if.sv | 16 +
 rtl/uut_perf_recorder.sv | 138 +++++++++++++
 2 files changed

// File: rtl/uut_perf_recorder_if.sv
// ============================================================================
// uut_perf_recorder_if : byte-wide valid/ready record stream
// Revision: 1.0
// ============================================================================
`default_nettype none

interface uut_perf_recorder_if;
  logic [7:0] rec_byte;
  logic       rec_valid;
  logic       rec_ready;

  modport master (output rec_byte, output rec_valid, input  rec_ready);
  modport slave  (input  rec_byte, input  rec_valid, output rec_ready);
endinterface

`default_nettype wire

// File: rtl/uut_perf_recorder.sv
// ============================================================================
// uut_perf_recorder : times uut_start->uut_finish and streams a 14-byte record
// Revision: 1.0
// ============================================================================
`default_nettype none

module uut_perf_recorder #(
  parameter int unsigned CNT_W          = 48,
  parameter logic [63:0] TIMEOUT_CYCLES = 64'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uut_start,
  input  logic                  uut_finish,
  input  logic [31:0]           uut_n_blocks,
  input  logic [4:0]            uut_sclk_speed,
  input  logic                  uut_cmd18,
  uut_perf_recorder_if.master   rec,
  output logic                  busy,
  output logic                  timeout,
  output logic [CNT_W-1:0]      cycles,
  output logic                  done
);

  localparam logic [1:0]       ST_IDLE    = 2'd0;
  localparam logic [1:0]       ST_MEASURE = 2'd1;
  localparam logic [1:0]       ST_SEND    = 2'd2;
  localparam logic [3:0]       LAST_IDX   = 4'd13;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] TO_VAL     = TIMEOUT_CYCLES[CNT_W-1:0];
  localparam bit               TO_EN      = (TIMEOUT_CYCLES != 64'd0);

  logic [1:0]       state;
  logic             start_q;
  logic [CNT_W-1:0] count;
  logic [31:0]      n_blocks_q;
  logic [4:0]       sclk_q;
  logic             cmd18_q;
  logic [3:0]       byte_idx;
  logic             valid_q;
  logic             start_edge;
  logic [63:0]      cycles_64;
  logic [7:0]       byte_mux;

  assign start_edge = uut_start & ~start_q;
  assign cycles_64  = 64'(cycles);
  assign busy       = (state != ST_IDLE);

  always_comb begin
    byte_mux = 8'h00;
    case (byte_idx)
      4'd0:    byte_mux = 8'hA5;
      4'd1:    byte_mux = n_blocks_q[31:24];
      4'd2:    byte_mux = n_blocks_q[23:16];
      4'd3:    byte_mux = n_blocks_q[15:8];
      4'd4:    byte_mux = n_blocks_q[7:0];
      4'd5:    byte_mux = {timeout, 1'b0, cmd18_q, sclk_q};
      4'd6:    byte_mux = cycles_64[63:56];
      4'd7:    byte_mux = cycles_64[55:48];
      4'd8:    byte_mux = cycles_64[47:40];
      4'd9:    byte_mux = cycles_64[39:32];
      4'd10:   byte_mux = cycles_64[31:24];
      4'd11:   byte_mux = cycles_64[23:16];
      4'd12:   byte_mux = cycles_64[15:8];
      4'd13:   byte_mux = cycles_64[7:0];
      default: byte_mux = 8'h00;
    endcase
  end

  // Gating by valid keeps the byte at zero whenever nothing is being offered.
  assign rec.rec_valid = valid_q;
  assign rec.rec_byte  = valid_q ? byte_mux : 8'h00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      start_q    <= 1'b0;
      count      <= '0;
      cycles     <= '0;
      timeout    <= 1'b0;
      n_blocks_q <= 32'd0;
      sclk_q     <= 5'd0;
      cmd18_q    <= 1'b0;
      byte_idx   <= 4'd0;
      valid_q    <= 1'b0;
      done       <= 1'b0;
    end else begin
      start_q <= uut_start;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            n_blocks_q <= uut_n_blocks;
            sclk_q     <= uut_sclk_speed;
            cmd18_q    <= uut_cmd18;
            count      <= CNT_ONE;
            state      <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          // Finish takes priority over a timeout landing in the same cycle.
          if (uut_finish) begin
            cycles   <= count;
            timeout  <= 1'b0;
            byte_idx <= 4'd0;
            state    <= ST_SEND;
          end else if (TO_EN && (count == TO_VAL)) begin
            cycles   <= count;
            timeout  <= 1'b1;
            byte_idx <= 4'd0;
            state    <= ST_SEND;
          end else if (count != CNT_MAX) begin
            count <= count + CNT_ONE;
          end
        end
        ST_SEND: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (rec.rec_ready) begin
            if (byte_idx == LAST_IDX) begin
              valid_q  <= 1'b0;
              byte_idx <= 4'd0;
              done     <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              byte_idx <= byte_idx + 4'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
